// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue/writeback stage.
package alu_issue_pkg;

  // ALU op select codes.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_PASSB = 4'd5;

  // Instruction format selectors (instr[31:30]).
  localparam logic [1:0] OP_FMT2 = 2'b00;
  localparam logic [1:0] OP_FMT3 = 2'b10;

  // Format 2 op2 code for SETHI (instr[24:22]).
  localparam logic [2:0] OP2_SETHI = 3'b100;

  // Format 3 op3 codes (instr[24:19]); op3[4] selects the cc variant.
  localparam logic [5:0] OP3_ADD = 6'b000000;
  localparam logic [5:0] OP3_AND = 6'b000001;
  localparam logic [5:0] OP3_OR  = 6'b000010;
  localparam logic [5:0] OP3_XOR = 6'b000011;
  localparam logic [5:0] OP3_SUB = 6'b000100;

  // Issue FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder: instruction + operands -> ALU controls and writeback attributes.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [31:0]   i_instr,
  input  logic [DW-1:0] i_rs1_val,
  input  logic [DW-1:0] i_rs2_val,
  output logic [3:0]    o_alu_op,
  output logic [DW-1:0] o_alu_a,
  output logic [DW-1:0] o_alu_b,
  output logic [4:0]    o_rd,
  output logic          o_is_cc,
  output logic          o_illegal,
  output logic          o_we
);

  logic [1:0] w_op;
  logic [5:0] w_op3;
  logic [2:0] w_op2;

  assign w_op  = i_instr[31:30];
  assign w_op3 = i_instr[24:19];
  assign w_op2 = i_instr[24:22];
  assign o_rd  = i_instr[29:25];

  // Map the encoding to ALU controls; anything unrecognised stays illegal with zero operands.
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_alu_a   = '0;
    o_alu_b   = '0;
    o_is_cc   = 1'b0;
    o_illegal = 1'b1;
    if (w_op == OP_FMT3) begin
      // op3[4] is masked out so plain and cc variants share one lookup.
      o_illegal = 1'b0;
      case ({w_op3[5], w_op3[3:0]})
        {OP3_ADD[5], OP3_ADD[3:0]}: o_alu_op = ALU_ADD;
        {OP3_AND[5], OP3_AND[3:0]}: o_alu_op = ALU_AND;
        {OP3_OR[5],  OP3_OR[3:0]}:  o_alu_op = ALU_OR;
        {OP3_XOR[5], OP3_XOR[3:0]}: o_alu_op = ALU_XOR;
        {OP3_SUB[5], OP3_SUB[3:0]}: o_alu_op = ALU_SUB;
        default:                    o_illegal = 1'b1;
      endcase
      if (!o_illegal) begin
        o_is_cc = w_op3[4];
        o_alu_a = i_rs1_val;
        if (i_instr[13]) begin
          o_alu_b = {{(DW-13){i_instr[12]}}, i_instr[12:0]};
        end else begin
          o_alu_b = i_rs2_val;
        end
      end
    end else if (w_op == OP_FMT2 && w_op2 == OP2_SETHI) begin
      o_illegal = 1'b0;
      o_alu_op  = ALU_PASSB;
      o_alu_b   = DW'({i_instr[21:0], 10'b0});
    end
  end

  assign o_we = !o_illegal && (o_rd != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage: registers one instruction, drives the external ALU for
// one cycle, captures the result and condition codes, and holds a writeback beat.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [DW-1:0] in_rs1_val,
  input  logic [DW-1:0] in_rs2_val,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_zf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_rd,
  output logic [DW-1:0] out_data,
  output logic          out_we,
  output logic          out_illegal,
  output logic          icc_z,
  output logic          icc_n
);

  state_t        r_state;
  state_t        w_next;
  logic          w_take;

  logic [31:0]   r_instr;
  logic [DW-1:0] r_rs1;
  logic [DW-1:0] r_rs2;

  logic [4:0]    r_rd;
  logic [DW-1:0] r_data;
  logic          r_we;
  logic          r_illegal;
  logic          r_icc_z;
  logic          r_icc_n;

  logic [3:0]    w_dec_op;
  logic [DW-1:0] w_dec_a;
  logic [DW-1:0] w_dec_b;
  logic [4:0]    w_dec_rd;
  logic          w_dec_cc;
  logic          w_dec_illegal;
  logic          w_dec_we;

  alu_issue_decode #(.DW(DW)) u_decode (
    .i_instr   (r_instr),
    .i_rs1_val (r_rs1),
    .i_rs2_val (r_rs2),
    .o_alu_op  (w_dec_op),
    .o_alu_a   (w_dec_a),
    .o_alu_b   (w_dec_b),
    .o_rd      (w_dec_rd),
    .o_is_cc   (w_dec_cc),
    .o_illegal (w_dec_illegal),
    .o_we      (w_dec_we)
  );

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_next = in_valid ? ST_EXEC : ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_take = in_valid && in_ready;

  // ALU ports are driven only during EXEC so the ALU sees zeros otherwise.
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (r_state == ST_EXEC) begin
      alu_op = w_dec_op;
      alu_a  = w_dec_a;
      alu_b  = w_dec_b;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Capture the accepted instruction and operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (w_take) begin
      r_instr <= in_instr;
      r_rs1   <= in_rs1_val;
      r_rs2   <= in_rs2_val;
    end
  end

  // Load the writeback beat and condition codes at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd      <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
      r_icc_z   <= 1'b0;
      r_icc_n   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rd      <= w_dec_rd;
      r_data    <= alu_y;
      r_we      <= w_dec_we;
      r_illegal <= w_dec_illegal;
      if (w_dec_cc) begin
        r_icc_z <= alu_zf;
        r_icc_n <= alu_y[DW-1];
      end
    end
  end

  assign out_rd      = r_rd;
  assign out_data    = r_data;
  assign out_we      = r_we;
  assign out_illegal = r_illegal;
  assign icc_z       = r_icc_z;
  assign icc_n       = r_icc_n;

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequential issue/writeback stage that sits on the driving side of the combinational ALU. It accepts one SPARC-style instruction at a time with its source operand values, decodes it into `alu_op`, `a` and `b`, and drives those into the ALU. It then captures the ALU result `y` and zero flag `zf`, updates the integer condition codes, and presents a writeback beat to the register file under a valid/ready handshake.

## Interface
- `DW`, 32: datapath width; must match the ALU width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: an instruction and its operands are offered.
- `in_ready` out 1: the block accepts the offer this cycle.
- `in_instr` in 32: instruction word.
- `in_rs1_val` in DW: value of the rs1 register.
- `in_rs2_val` in DW: value of the rs2 register.
- `alu_op` out 4: op select to the ALU (0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=PASSB).
- `alu_a` out DW: ALU operand a.
- `alu_b` out DW: ALU operand b.
- `alu_y` in DW: ALU result.
- `alu_zf` in 1: ALU zero flag.
- `out_valid` out 1: writeback beat is valid.
- `out_ready` in 1: the consumer accepts the writeback beat.
- `out_rd` out 5: destination register number.
- `out_data` out DW: result to write.
- `out_we` out 1: write enable. Cleared for rd=0 and for illegal instructions.
- `out_illegal` out 1: the beat carries an unsupported encoding.
- `icc_z` out 1: zero condition code.
- `icc_n` out 1: negative condition code.

## Operation
- **FSM states:** IDLE, EXEC, DONE.
- **Input handshake:** `in_ready = (state==IDLE) | (state==DONE & out_ready)`. A transfer occurs when `in_valid & in_ready`. On a transfer, the instruction and operands are registered and the state goes to EXEC.
- **EXEC:** lasts exactly one cycle. The ALU ports are driven from the registered fields. At the end of the cycle, `alu_y` is captured into `out_data`, the `out_*` fields are set, and the state goes to DONE.
- **DONE:** `out_valid=1`. `out_rd`, `out_data`, `out_we` and `out_illegal` hold stable until `out_ready`. On `out_ready`, the next state is EXEC if a new input transfers in the same cycle, otherwise IDLE.
- **Decode, format 3 (op=[31:30]=2'b10, op3=[24:19]):**
  - ADD 000000 → ALU op 0
  - AND 000001 → 2
  - OR 000010 → 3
  - XOR 000011 → 4
  - SUB 000100 → 1
  - Setting op3[4] selects the cc variant (010000–010100).
  - `alu_a = rs1_val`.
  - If i=[13]=1, `alu_b` = simm13 [12:0] sign-extended to DW; otherwise `alu_b = rs2_val`.
- **Decode, SETHI (op=2'b00, op2=[24:22]=3'b100):** `alu_op=5`, `alu_b = {imm22[21:0], 10'b0}`, `alu_a = 0`.
- **Other encodings:** illegal. The ALU is driven with op 0 on zero operands, `out_illegal=1`, `out_we=0`, and the icc is not updated.
- **rd:** taken from [29:25]. rd=0 forces `out_we=0`; the beat is still emitted.
- **icc update:** cc variants only, at the end of EXEC: `icc_z <= alu_zf`, `icc_n <= alu_y[DW-1]`. Non-cc instructions leave the icc unchanged.
- **ALU ports outside EXEC:** `alu_op=0`, `alu_a=0`, `alu_b=0`.
- **Arithmetic:** performed by the ALU, modulo 2^DW. The block adds no carry or overflow logic.

## Timing
- **Reset values:** state=IDLE, `in_ready=1` (after reset), `out_valid=0`, `out_rd=0`, `out_data=0`, `out_we=0`, `out_illegal=0`, `icc_z=0`, `icc_n=0`, ALU ports 0.
- **Latency:** input transfer at edge N gives EXEC in cycle N..N+1 and `out_valid=1` from edge N+1.
- **Throughput:** one instruction per 2 cycles with `out_ready` held high.
- **Backpressure:** while DONE and `out_ready=0`, `in_ready=0` and all outputs are frozen.
- **Reset mid-operation:** `rst` asserted in any state returns to IDLE at the next edge. An in-flight beat is discarded and never emitted, and the icc is cleared.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. There is no other input-to-output combinational path except through the external ALU during EXEC.

## Structure
- **Package `alu_issue_pkg`:**
  - ALU op constants: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_PASSB=5.
  - op3/op2 codes.
  - The FSM state encoding.
- **Sub-module `alu_issue_decode`:** purely combinational. It maps instruction plus operands to `alu_op`, `alu_a`, `alu_b`, rd, `is_cc`, `illegal` and `we`. The top level holds the FSM and registers.
- **Bench:** the real ALU is instantiated alongside this block for integration.

## Test plan
- **Register ADD:** `in_instr=0x86004002` (add r1,r2,r3), rs1=5, rs2=7 → two edges later `out_valid=1`, `out_data=12`, `out_rd=3`, `out_we=1`; icc unchanged.
- **Immediate SUBcc:** rs1=10, simm13=10, rd=1 → `out_data=0`, `icc_z=1`, `icc_n=0`. A following ADD giving 4 leaves `icc_z=1`. A SUBcc with rs1=0, simm13=1 gives `out_data=0xFFFFFFFF`, `icc_n=1`, `icc_z=0`.
- **SETHI:** imm22=0x3FFFFF, rd=4 → `alu_op=5` during EXEC, `out_data=0xFFFFFC00`, `out_we=1`.
- **Backpressure:** `out_ready=0` for 5 cycles after `out_valid` → `out_data` and `out_rd` stable, `in_ready=0`. Release with `in_valid` high → back-to-back EXEC in the same edge; the second result appears 2 cycles later.
- **Illegal and rd=0:** op3=100101 → `out_illegal=1`, `out_we=0`, icc unchanged. A legal ADD with rd=0 → `out_we=0`, `out_illegal=0`.
- **Reset mid-operation:** `rst` high during EXEC → next cycle `out_valid=0`, `in_ready=1`, `icc_z=0`, and no beat is ever emitted for that instruction.
